iq_requant_packer: RTL

IQ_REQUANT_PACKER -- requirements
Module: iq_requant_packer

---
 rtl/iq_requant_packer.sv | 81 ++++++++
 1 files changed

// File: rtl/iq_requant_packer.sv
// Requantises 16-bit signed I/Q samples to OUT_BITS each and packs SPW samples
// MSB-first into 32-bit AXI-Stream words; tlast flushes a partial word zero-padded.
module iq_requant_packer #(
  parameter int OUT_BITS = 4,
  parameter int ROUND    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] i_tdata,
  input  logic        i_tvalid,
  output logic        i_tready,
  input  logic        i_tlast,
  output logic [31:0] o_tdata,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        o_tlast
);

  localparam int unsigned FW     = 32'(2 * OUT_BITS);
  localparam int unsigned SPW    = 32'(16 / OUT_BITS);
  localparam int unsigned SLOT_W = (SPW > 1) ? $clog2(SPW) : 1;
  localparam logic [15:0] RND_ADD = 16'(1 << (15 - OUT_BITS));
  localparam logic [OUT_BITS-1:0] SAT = OUT_BITS'((1 << (OUT_BITS - 1)) - 1);

  // Top OUT_BITS of a component, optionally rounded half-up with positive saturation
  function automatic logic [OUT_BITS-1:0] quant(input logic [15:0] c);
    logic [16:0] sum;
    sum = {c[15], c} + {1'b0, RND_ADD};
    if (ROUND == 0) return OUT_BITS'(c >> (16 - OUT_BITS));
    if (sum[16] != sum[15]) return SAT;
    return OUT_BITS'(sum[15:0] >> (16 - OUT_BITS));
  endfunction

  logic [SLOT_W-1:0] slot;
  logic [31:0]       acc;
  logic [FW-1:0]     field;
  logic [5:0]        shamt;
  logic [31:0]       word;
  logic              completing;
  logic              accept;

  // Field placement and handshake; only completing beats can be backpressured
  always_comb begin
    field      = {quant(i_tdata[31:16]), quant(i_tdata[15:0])};
    shamt      = 6'(32 - FW * (32'(slot) + 32'd1));
    word       = acc | (32'(field) << shamt);
    completing = (slot == SLOT_W'(SPW - 1)) || i_tlast;
    i_tready   = ~completing | ~o_tvalid | o_tready;
    accept     = i_tvalid & i_tready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot     <= '0;
      acc      <= '0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      o_tvalid <= 1'b0;
    end else if (clear) begin
      slot     <= '0;
      acc      <= '0;
      o_tvalid <= 1'b0;
    end else begin
      if (o_tvalid && o_tready) o_tvalid <= 1'b0;
      if (accept) begin
        if (completing) begin
          o_tdata  <= word;
          o_tlast  <= i_tlast;
          o_tvalid <= 1'b1;
          slot     <= '0;
          acc      <= '0;
        end else begin
          acc  <= word;
          slot <= slot + SLOT_W'(1);
        end
      end
    end
  end

endmodule
